std_fifo_flex: RTL and testbench

- Parametrised synchronous FIFO; the next generation of the team's standard single-clock FIFO.
- Adds three things:
  - selectable output mode: registered-read or first-word-fall-through (FWFT);
  - run-time almost-empty/almost-full thresholds;
  - sticky overflow/underflow error flags. Illegal operations are dropped, never fatal.
- Used wherever producer/consumer pipelines in the design need buffering with flow control.

---
 rtl/std_fifo_pkg.sv | 24 ++
 rtl/std_fifo_ram.sv | 35 +++
 rtl/std_fifo_flex.sv | 173 +++++++++++++++++
 tb/tb_std_fifo_flex.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_fifo_pkg.sv
// Shared definitions for the standard FIFO family: output mode constants and
// the ceiling-log2 helper used to size pointers and counters.
`timescale 1ns/1ps
package std_fifo_pkg;

    // Output mode selectors for the FWFT parameter.
    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2: log2(1)=0, log2(2)=1, log2(5)=3, log2(64)=6.
    // Values of 0 or 1 both return 0.
    function automatic int log2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/std_fifo_ram.sv
// Simple dual-port storage for the standard FIFO: one write port, one read
// port, registered read data, no reset. A read and a write to the same address
// at the same edge return the previously stored word.
`timescale 1ns/1ps
module std_fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the incoming word when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered read, sees the contents from before this edge's write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/std_fifo_flex.sv
// Parametrised single-clock FIFO with selectable registered-read or
// first-word-fall-through output, run-time almost-empty/almost-full thresholds
// and sticky overflow/underflow flags. Illegal pushes/pops are simply dropped.
//
// Datapath: the storage read port is always prefetching the word at the read
// pointer as it will be after the current edge, so the oldest stored word is
// available at every edge. When a word is written into the very slot being
// prefetched, the storage returns the old contents; a one-word bypass register
// captures the written data and substitutes it for that one cycle.
//
// In registered mode q is loaded from the oldest stored word on each accepted
// pop. In FWFT mode q is the head register: it holds the oldest word whenever
// the FIFO is non-empty, is loaded straight from d when pushing into an empty
// FIFO, and is refilled from storage when popped. count includes the head.
`timescale 1ns/1ps
module std_fifo_flex
    import std_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int FWFT  = FIFO_MODE_REG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      d,
    output logic [WIDTH-1:0]      q,
    output logic                  full,
    output logic                  empty,
    output logic [log2(DEPTH):0]  count,
    input  logic [log2(DEPTH):0]  ae_thresh,
    input  logic [log2(DEPTH):0]  af_thresh,
    output logic                  almost_empty,
    output logic                  almost_full,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              ADDR_W    = log2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] PTR_ZERO  = '0;
    localparam bit              IS_FWFT   = (FWFT == FIFO_MODE_FWFT);

    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [ADDR_W:0]  rd_ptr_nxt;
    logic [ADDR_W:0]  count_nxt;
    logic             pop_acc;
    logic             push_acc;
    logic             ram_we;
    logic             ram_has_data;
    logic             load_from_ram;
    logic             load_from_d;
    logic             stale;
    logic             stale_nxt;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] bypass_data;
    logic [WIDTH-1:0] ram_head;

    // Acceptance rules and the next occupancy.
    always_comb begin
        pop_acc   = pop & ~empty;
        push_acc  = push & (~full | pop_acc);
        count_nxt = count + {{ADDR_W{1'b0}}, push_acc} - {{ADDR_W{1'b0}}, pop_acc};
    end

    // Routing of words between d, storage and the output register.
    always_comb begin
        load_from_ram = 1'b0;
        load_from_d   = 1'b0;
        ram_we        = push_acc;
        ram_has_data  = (wr_ptr != rd_ptr);
        if (IS_FWFT) begin
            if (pop_acc || empty) begin
                if (ram_has_data) begin
                    load_from_ram = 1'b1;
                end else if (push_acc) begin
                    load_from_d = 1'b1;
                    ram_we      = 1'b0;
                end
            end
        end else begin
            load_from_ram = pop_acc;
        end
        rd_ptr_nxt = rd_ptr + (load_from_ram ? PTR_ONE : PTR_ZERO);
        stale_nxt  = ram_we && (wr_ptr[ADDR_W-1:0] == rd_ptr_nxt[ADDR_W-1:0]);
    end

    assign ram_head = stale ? bypass_data : ram_rdata;

    std_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (d),
        .re    (1'b1),
        .raddr (rd_ptr_nxt[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // Storage pointers advance on writes into and reads out of storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Occupancy with full/empty flags registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == PTR_ZERO);
        end
    end

    // Output register: reloaded only when a new word is delivered, else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load_from_ram) begin
            q <= ram_head;
        end else if (load_from_d) begin
            q <= d;
        end
    end

    // Marks when the storage read returned pre-write data for the prefetched slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stale <= 1'b0;
        end else begin
            stale <= stale_nxt;
        end
    end

    // Copy of the last written word, used while the prefetch is stale.
    always_ff @(posedge clk) begin
        bypass_data <= d;
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (push & ~push_acc) | (overflow & ~err_clr);
            underflow <= (pop & ~pop_acc) | (underflow & ~err_clr);
        end
    end

    assign almost_empty = (count <= ae_thresh);
    assign almost_full  = (count >= af_thresh);

endmodule

// File: tb/tb_std_fifo_flex.sv
// Self-checking bench for std_fifo_flex: a registered-read and an FWFT instance
// share the same stimulus and are compared every cycle against a queue model,
// with directed scenarios adding hand-computed expectations.
`timescale 1ns/1ps
module tb_std_fifo_flex;

    localparam int DEPTH = 8;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       push      = 1'b0;
    logic       pop       = 1'b0;
    logic       err_clr   = 1'b0;
    logic [7:0] d         = 8'h00;
    logic [3:0] ae_thresh = 4'd0;
    logic [3:0] af_thresh = 4'd8;

    logic [7:0] r_q, f_q;
    logic       r_full, f_full, r_empty, f_empty;
    logic [3:0] r_count, f_count;
    logic       r_ae, f_ae, r_af, f_af;
    logic       r_ovf, f_ovf, r_unf, f_unf;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_fifo[$];
    logic [7:0] m_q_reg  = 8'h00;
    logic [7:0] m_q_fwft = 8'h00;
    logic       m_ovf    = 1'b0;
    logic       m_unf    = 1'b0;

    std_fifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .q(r_q),
        .full(r_full), .empty(r_empty), .count(r_count),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh),
        .almost_empty(r_ae), .almost_full(r_af),
        .err_clr(err_clr), .overflow(r_ovf), .underflow(r_unf)
    );

    std_fifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .q(f_q),
        .full(f_full), .empty(f_empty), .count(f_count),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh),
        .almost_empty(f_ae), .almost_full(f_af),
        .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then return to idle.
    task automatic applyStimulus(input logic p_push, input logic p_pop, input logic [7:0] p_d, input logic p_clr);
        push    = p_push;
        pop     = p_pop;
        d       = p_d;
        err_clr = p_clr;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    // Behavioural model: a word queue plus the output rules of each mode.
    initial begin
        bit pa;
        bit wa;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_fifo.delete();
                m_q_reg  = 8'h00;
                m_q_fwft = 8'h00;
                m_ovf    = 1'b0;
                m_unf    = 1'b0;
            end else begin
                pa    = pop && (m_fifo.size() > 0);
                wa    = push && ((m_fifo.size() < DEPTH) || pa);
                m_ovf = (push && !wa) || (m_ovf && !err_clr);
                m_unf = (pop && !pa) || (m_unf && !err_clr);
                if (pa) m_q_reg = m_fifo.pop_front();
                if (wa) m_fifo.push_back(d);
                if (m_fifo.size() > 0) m_q_fwft = m_fifo[0];
            end
        end
    end

    task automatic compareAll();
        int n;
        n = m_fifo.size();
        checkOutput("reg_count",  32'(r_count), n);
        checkOutput("fwft_count", 32'(f_count), n);
        checkOutput("reg_full",   32'(r_full),  32'(n == DEPTH));
        checkOutput("fwft_full",  32'(f_full),  32'(n == DEPTH));
        checkOutput("reg_empty",  32'(r_empty), 32'(n == 0));
        checkOutput("fwft_empty", 32'(f_empty), 32'(n == 0));
        checkOutput("reg_q",      32'(r_q),     32'(m_q_reg));
        checkOutput("fwft_q",     32'(f_q),     32'(m_q_fwft));
        checkOutput("reg_ae",     32'(r_ae),    32'(n <= int'(ae_thresh)));
        checkOutput("fwft_ae",    32'(f_ae),    32'(n <= int'(ae_thresh)));
        checkOutput("reg_af",     32'(r_af),    32'(n >= int'(af_thresh)));
        checkOutput("fwft_af",    32'(f_af),    32'(n >= int'(af_thresh)));
        checkOutput("reg_ovf",    32'(r_ovf),   32'(m_ovf));
        checkOutput("fwft_ovf",   32'(f_ovf),   32'(m_ovf));
        checkOutput("reg_unf",    32'(r_unf),   32'(m_unf));
        checkOutput("fwft_unf",   32'(f_unf),   32'(m_unf));
    endtask

    // Every falling edge the outputs of both instances must match the model.
    initial begin
        forever begin
            @(negedge clk);
            compareAll();
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(r_count), 0);
        checkOutput("rst_empty", 32'(r_empty), 1);
        checkOutput("rst_full",  32'(r_full),  0);
        checkOutput("rst_rq",    32'(r_q),     0);
        checkOutput("rst_fq",    32'(f_q),     0);
        rst = 1'b1;

        // Fill and drain
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
            if (i == 0) begin
                checkOutput("fill_fwft_first_q", 32'(f_q), 32'h10);
                checkOutput("fill_fwft_not_empty", 32'(f_empty), 0);
            end
        end
        checkOutput("fill_reg_full",   32'(r_full),  1);
        checkOutput("fill_fwft_full",  32'(f_full),  1);
        checkOutput("fill_reg_count",  32'(r_count), 8);
        checkOutput("fill_fwft_count", 32'(f_count), 8);
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_fwft_head", 32'(f_q), 32'(16 + i));
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkOutput("drain_reg_q", 32'(r_q), 32'(16 + i));
        end
        checkOutput("drain_reg_empty",  32'(r_empty), 1);
        checkOutput("drain_fwft_empty", 32'(f_empty), 1);

        // Overflow
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hAA, 1'b0);
        checkOutput("ovf_reg_flag",  32'(r_ovf),   1);
        checkOutput("ovf_fwft_flag", 32'(f_ovf),   1);
        checkOutput("ovf_count",     32'(r_count), 8);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ovf_clr_reg",  32'(r_ovf), 0);
        checkOutput("ovf_clr_fwft", 32'(f_ovf), 0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("ovf_fwft_head", 32'(f_q), 32'(32 + i));
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkOutput("ovf_reg_q", 32'(r_q), 32'(32 + i));
        end

        // Underflow from reset
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("unf_flag",  32'(r_unf),   1);
        checkOutput("unf_count", 32'(r_count), 0);
        checkOutput("unf_rq",    32'(r_q),     0);
        checkOutput("unf_fq",    32'(f_q),     0);
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b0);
        checkOutput("unf_pp_flag",  32'(f_unf),   1);
        checkOutput("unf_pp_count", 32'(r_count), 1);
        checkOutput("unf_pp_fq",    32'(f_q),     32'h55);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("unf_pp_rq", 32'(r_q), 32'h55);

        // Simultaneous push/pop at full across pointer wrap
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h38 + i), 1'b0);
            checkOutput("pp_reg_q",  32'(r_q),     32'(48 + i));
            checkOutput("pp_fwft_q", 32'(f_q),     32'(49 + i));
            checkOutput("pp_count",  32'(f_count), 8);
            checkOutput("pp_full",   32'(r_full),  1);
        end
        checkOutput("pp_no_ovf", 32'(r_ovf), 0);
        checkOutput("pp_no_unf", 32'(f_unf), 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
            checkOutput("pp_drain_reg_q", 32'(r_q), 32'(68 + i));
        end

        // Thresholds
        ae_thresh = 4'd2;
        af_thresh = 4'd6;
        #1;
        checkOutput("th_ae_at0", 32'(r_ae), 1);
        checkOutput("th_af_at0", 32'(f_af), 0);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(1'b1, 1'b0, 8'(c), 1'b0);
            checkOutput("th_reg_ae",  32'(r_ae), 32'(c <= 2));
            checkOutput("th_fwft_af", 32'(f_af), 32'(c >= 6));
            if (c == 7) begin
                af_thresh = 4'd8;
                #1;
                checkOutput("th_af_drop_reg",  32'(r_af), 0);
                checkOutput("th_af_drop_fwft", 32'(f_af), 0);
            end
        end
        checkOutput("th_af_full", 32'(r_af), 1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);

        // Async reset mid-stream
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        checkOutput("ar_pre_count", 32'(r_count), 5);
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_reg_count",  32'(r_count), 0);
        checkOutput("ar_fwft_count", 32'(f_count), 0);
        checkOutput("ar_empty",      32'(f_empty), 1);
        checkOutput("ar_rq",         32'(r_q),     0);
        checkOutput("ar_fq",         32'(f_q),     0);
        checkOutput("ar_unf",        32'(r_unf),   0);
        checkOutput("ar_ovf",        32'(f_ovf),   0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
        checkOutput("ar_fwft_q33", 32'(f_q),     32'h33);
        checkOutput("ar_count1",   32'(r_count), 1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("ar_reg_q33",  32'(r_q),     32'h33);
        checkOutput("ar_empty2",   32'(r_empty), 1);

        // Randomised traffic with drifting push/pop bias
        for (int n = 0; n < 1500; n++) begin
            int bias;
            bias = ((n / 150) % 2 == 0) ? 75 : 25;
            if (n % 100 == 0) begin
                ae_thresh = 4'($urandom_range(0, 8));
                af_thresh = 4'($urandom_range(0, 8));
            end
            applyStimulus(1'($urandom_range(0, 99) < bias),
                          1'($urandom_range(0, 99) < (100 - bias)),
                          8'($urandom),
                          1'($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
